// File: rtl/vigna_bus_arbiter.sv
// vigna_bus_arbiter: N-master to 1-slave valid/ready arbiter; the grant is held for a whole transaction.
// Latency: a request in IDLE reaches s_valid one cycle later; m_ready follows s_ready combinationally.
// Backpressure: the granted master waits on s_ready; other masters are held off until the next IDLE.
//
// Optional feature macro: VIGNA_ARB_RR_EN
//   undefined -> fixed priority, the lowest index with m_valid wins.
//   defined   -> round-robin from a pointer that advances past each completed grant.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   m_valid / m_ready            per-master request / completion (m_ready one-hot or zero)
//   m_addr / m_wdata / m_wstrb   packed per-master request payload, master i at slice i
//   m_rdata                      slave read data broadcast to every master
//   s_valid / s_ready            slave request / completion
//   s_addr / s_wdata / s_wstrb   payload of the granted master, zero while s_valid=0
//   s_rdata                      slave read data
//   grant                        index of the current or last granted master

module vigna_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  localparam int SW         = DATA_WIDTH / 8,
  localparam int GW         = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  output logic [NUM_MASTERS-1:0]        m_ready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*SW-1:0]     m_wstrb,
  output logic [DATA_WIDTH-1:0]         m_rdata,
  output logic                          s_valid,
  input  logic                          s_ready,
  output logic [ADDR_WIDTH-1:0]         s_addr,
  output logic [DATA_WIDTH-1:0]         s_wdata,
  output logic [SW-1:0]                 s_wstrb,
  input  logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [GW-1:0]                 grant
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t       state, state_nxt;
  logic [GW-1:0] grant_nxt;
  logic [GW-1:0] winner;
  logic          handshake;
  int            gi;

  assign gi        = int'(grant);
  assign m_rdata   = s_rdata;
  assign s_valid   = (state == BUSY) && m_valid[gi];
  assign handshake = s_valid && s_ready;

`ifdef VIGNA_ARB_RR_EN
  logic [GW-1:0] ptr, ptr_nxt;

  // Scan from ptr upwards, wrapping modulo NUM_MASTERS so a non-power-of-two
  // count never selects an index that does not exist.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && m_valid[idx]) begin
        winner = GW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Only a completed handshake moves the pointer; an abort leaves it alone.
  always_comb begin
    ptr_nxt = ptr;
    if (handshake) begin
      if (gi == NUM_MASTERS - 1) ptr_nxt = '0;
      else                       ptr_nxt = GW'(gi + 1);
    end
  end
`else
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && m_valid[k]) begin
        winner = GW'(k);
        found  = 1'b1;
      end
    end
  end
`endif

  // Next-state: grant is only rewritten on the IDLE->BUSY step, so it stays
  // stable for the whole BUSY period and reports the last master afterwards.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (|m_valid) begin
          state_nxt = BUSY;
          grant_nxt = winner;
        end
      end
      BUSY: begin
        // Either a completed handshake or the master withdrawing its request
        // ends the transaction; both return to IDLE.
        if (handshake || !m_valid[gi]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_ready = '0;
    if (handshake) m_ready[gi] = 1'b1;
  end

  // Payload mux; zeroed whenever no request is presented to the slave.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (s_valid) begin
      s_addr  = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      s_wdata = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      s_wstrb = m_wstrb[gi*SW +: SW];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      grant <= '0;
`ifdef VIGNA_ARB_RR_EN
      ptr   <= '0;
`endif
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
`ifdef VIGNA_ARB_RR_EN
      ptr   <= ptr_nxt;
`endif
    end
  end

endmodule
